// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// A request is captured in IDLE, the unit stays busy for a fixed number of
// cycles, and HI/LO are written at the final edge. mthi/mtlo write at once.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
// (md_op 7-10); without it those encodings behave as no-ops.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } state_e;

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int          CW         = $clog2(MAX_CYCLES + 1);

   state_e        state, state_next;
   logic [CW-1:0] count, count_next;
   op_e           op_q;
   logic [31:0]   a_q, b_q;
   logic          is_mul_op, is_div_op;
   logic          accept, finish;

   logic [63:0]   prod_s, prod_u;
   logic          div_signed;
   logic [31:0]   num, den_mag, den, quot_mag, rem_mag, quot, rem;
   logic          res_we;
   logic [63:0]   res;

   // Classify the incoming request into multiply-class and divide-class ops
   always_comb begin
      is_mul_op = 1'b0;
      is_div_op = 1'b0;
      case (md_op)
         OP_MULT, OP_MULTU: is_mul_op = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul_op = 1'b1;
`endif
         OP_DIV, OP_DIVU: is_div_op = 1'b1;
         default: ;
      endcase
   end

   // Next-state and counter logic: accept only in IDLE, finish when count hits 1
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_next = state;
      count_next = count;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start && is_mul_op) begin
               state_next = MUL;
               count_next = CW'(MULT_CYCLES);
               accept     = 1'b1;
            end else if (start && is_div_op) begin
               state_next = DIV;
               count_next = CW'(DIV_CYCLES);
               accept     = 1'b1;
            end
         end
         MUL, DIV: begin
            if (count == CW'(1)) begin
               state_next = IDLE;
               count_next = '0;
               finish     = 1'b1;
            end else begin
               count_next = count - CW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   // State and counter registers; reset wins over any request in the same cycle
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Operand capture on acceptance
   always_ff @(posedge clk) begin
      // NOTE: operand registers have no reset; they are only consumed after a fresh capture.
      if (accept) begin
         a_q  <= A;
         b_q  <= B;
         op_q <= op_e'(md_op);
      end
   end

   // Arithmetic datapath: signed/unsigned products and a shared magnitude divider
   always_comb begin
      prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u     = {32'd0, a_q} * {32'd0, b_q};
      div_signed = (op_q == OP_DIV);
      num        = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
      den_mag    = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
      // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
      den        = (b_q == 32'd0) ? 32'd1 : den_mag;
      quot_mag   = num / den;
      rem_mag    = num % den;
      // Quotient truncates toward zero; remainder follows the dividend's sign.
      quot       = (div_signed && (a_q[31] ^ b_q[31])) ? (32'd0 - quot_mag) : quot_mag;
      rem        = (div_signed && a_q[31]) ? (32'd0 - rem_mag) : rem_mag;
   end

   // Select the completion result and whether it is committed to HI/LO
   always_comb begin
      res_we = 1'b0;
      res    = {HI, LO};
      if (finish) begin
         case (op_q)
            OP_MULT:  begin res_we = 1'b1; res = prod_s; end
            OP_MULTU: begin res_we = 1'b1; res = prod_u; end
            OP_DIV, OP_DIVU: begin
               if (b_q != 32'd0) begin
                  res_we = 1'b1;
                  res    = {rem, quot};
               end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res_we = 1'b1; res = {HI, LO} + prod_s; end
            OP_MADDU: begin res_we = 1'b1; res = {HI, LO} + prod_u; end
            OP_MSUB:  begin res_we = 1'b1; res = {HI, LO} - prod_s; end
            OP_MSUBU: begin res_we = 1'b1; res = {HI, LO} - prod_u; end
`endif
            default: ;
         endcase
      end
   end

   // HI/LO registers: cleared by reset, written on completion or by mthi/mtlo in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (res_we) begin
         {HI, LO} <= res;
      end else if (state == IDLE && start) begin
         if (md_op == OP_MTHI) HI <= A;
         else if (md_op == OP_MTLO) LO <= A;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. Stimulus pushes the expected {HI,LO} of each
// busy operation; a monitor pops and compares when busy falls. The reference
// model computes results with plain 64-bit arithmetic.
module tb_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] A     = 32'd0;
   logic [31:0] B     = 32'd0;
   logic        busy;
   logic [31:0] HI, LO;

   mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] hilo;
      string       name;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] model  = 64'd0;   // reference {HI,LO}

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Number of busy cycles an accepted request should occupy
   function automatic int busy_len(input logic [3:0] op);
      case (op)
         4'd1, 4'd2: return MC;
         4'd3, 4'd4: return DC;
`ifdef MDU_MADD_EN
         4'd7, 4'd8, 4'd9, 4'd10: return MC;
`endif
         default: return 0;
      endcase
   endfunction

   // Reference result of a busy-class operation given the current {HI,LO}
   function automatic logic [63:0] model_op(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc);
      logic signed [63:0] sa, sb, sq, sr;
      logic [63:0]        ua, ub, uq, ur, ps, pu;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ps = sa * sb;
      pu = ua * ub;
      case (op)
         4'd1: return ps;
         4'd2: return pu;
         4'd3: begin
            if (b == 32'd0) return acc;
            sq = sa / sb;
            sr = sa % sb;
            return {sr[31:0], sq[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return acc;
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
`ifdef MDU_MADD_EN
         4'd7:  return acc + ps;
         4'd8:  return acc + pu;
         4'd9:  return acc - ps;
         4'd10: return acc - pu;
`endif
         default: return acc;
      endcase
   endfunction

   // Monitor: on each completion (busy falling not caused by reset) compare against the scoreboard
   logic prev_busy  = 1'b0;
   logic prev_reset = 1'b1;
   always @(negedge clk) begin
      if (prev_busy && !busy && !prev_reset) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_done", 64'(exp_q.size()), 64'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, {HI, LO}, e.hilo);
         end
      end
      prev_busy  = busy;
      prev_reset = reset;
   end

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      model = 64'd0;
      exp_q.delete();
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_hilo", {HI, LO}, 64'd0);
   endtask

   task automatic write_hilo(input string name, input logic [3:0] op, input logic [31:0] a);
      start = 1'b1;
      md_op = op;
      A     = a;
      tick();
      start = 1'b0;
      md_op = 4'd0;
      if (op == 4'd5) model[63:32] = a;
      else            model[31:0]  = a;
      check({name, "_busy"}, 64'(busy), 64'd0);
      check({name, "_hilo"}, {HI, LO}, model);
   endtask

   // Issue one request and follow it to completion. poke_cycle injects a mult
   // request in that busy cycle; rst_cycle asserts reset in that busy cycle.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int poke_cycle, input int rst_cycle);
      logic [63:0] pre, post;
      int n, cnt;
      pre  = model;
      n    = busy_len(op);
      post = model_op(op, a, b, model);
      if (n > 0 && rst_cycle == 0) exp_q.push_back('{post, name});
      start = 1'b1;
      md_op = op;
      A     = a;
      B     = b;
      tick();
      start = 1'b0;
      md_op = 4'd0;
      cnt   = 0;
      while (busy && cnt < 64) begin
         check({name, "_hold"}, {HI, LO}, pre);
         if (cnt + 1 == poke_cycle) begin
            start = 1'b1;
            md_op = 4'd1;
            A     = 32'hFFFF_FFFF;
            B     = 32'h0000_0002;
         end
         if (cnt + 1 == rst_cycle) reset = 1'b1;
         cnt++;
         tick();
         start = 1'b0;
         md_op = 4'd0;
         reset = 1'b0;
      end
      if (busy) check({name, "_timeout"}, 64'(busy), 64'd0);
      if (rst_cycle > 0) begin
         check({name, "_busy_len"}, 64'(cnt), 64'(rst_cycle));
         model = 64'd0;
      end else begin
         check({name, "_busy_len"}, 64'(cnt), 64'(n));
         model = post;
      end
      check({name, "_hilo"}, {HI, LO}, model);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] edges [5];
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      edges[0] = 32'h0000_0000;
      edges[1] = 32'h0000_0001;
      edges[2] = 32'hFFFF_FFFF;
      edges[3] = 32'h8000_0000;
      edges[4] = 32'h7FFF_FFFF;

      do_reset();

      run_op("mult_m2x3", 4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
      check("mult_m2x3_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);

      run_op("divu_7_2", 4'd4, 32'd7, 32'd2, 0, 0);
      check("divu_7_2_const", {HI, LO}, {32'd1, 32'd3});

      run_op("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
      check("div_m7_2_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      write_hilo("mthi_1234", 4'd5, 32'h0000_1234);
      run_op("div_by0", 4'd3, 32'd5, 32'd0, 0, 0);
      check("div_by0_const", {HI, LO}, {32'h0000_1234, 32'hFFFF_FFFD});

      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      check("div_ovf_const", {HI, LO}, {32'd0, 32'h8000_0000});

      run_op("divu_poke", 4'd4, 32'd100, 32'd7, 2, 0);
      check("divu_poke_const", {HI, LO}, {32'd2, 32'd14});

      run_op("mult_rst", 4'd1, 32'h0001_0000, 32'h0001_0000, 0, 3);
      for (int i = 0; i < MC + 2; i++) begin
         check("mult_rst_quiet_hilo", {HI, LO}, 64'd0);
         check("mult_rst_quiet_busy", 64'(busy), 64'd0);
         tick();
      end

      write_hilo("mthi_0", 4'd5, 32'd0);
      write_hilo("mtlo_1", 4'd6, 32'd1);
      run_op("madd_2x3", 4'd7, 32'd2, 32'd3, 0, 0);
`ifdef MDU_MADD_EN
      check("madd_const", {HI, LO}, {32'd0, 32'd7});
`else
      check("madd_const", {HI, LO}, {32'd0, 32'd1});
`endif

      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0:       ra = $urandom();
            1:       ra = 32'($urandom_range(0, 9));
            default: ra = edges[$urandom_range(0, 4)];
         endcase
         case ($urandom_range(0, 2))
            0:       rb = $urandom();
            1:       rb = 32'($urandom_range(0, 9));
            default: rb = edges[$urandom_range(0, 4)];
         endcase
         if (rop == 4'd5 || rop == 4'd6) write_hilo("rand_mtx", rop, ra);
         else run_op("rand_op", rop, ra, rb, 0, 0);
      end

      tick();
      tick();
      check("sb_drain", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, the number of busy cycles for a multiply (madd/msub included).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, the number of busy cycles for a divide.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port start, input, 1 bit: request strobe qualifying md_op, A and B.
REQ-006 SHALL have port md_op, input, 4 bits, with encoding 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 none.
REQ-007 SHALL have port A, input, 32 bits: rs operand; mthi/mtlo source.
REQ-008 SHALL have port B, input, 32 bits: rt operand.
REQ-009 SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-010 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL and DIV plus a down-counter; busy = (state != IDLE).
REQ-013 In IDLE, start with md_op 1/2/7-10 SHALL latch A, B and op, load the counter with MULT_CYCLES and enter MUL; busy SHALL be 1 from the next cycle.
REQ-014 In IDLE, start with md_op 3/4 SHALL latch A, B and op, load the counter with DIV_CYCLES and enter DIV.
REQ-015 The counter SHALL decrement each cycle in MUL/DIV; at the cycle where it reaches 1, HI/LO SHALL be updated at that edge and the state SHALL return to IDLE, so busy is high for exactly N cycles.
REQ-016 In IDLE, start with md_op 5 SHALL write HI=A (md_op 6: LO=A) at that edge, without asserting busy.
REQ-017 start while busy SHALL be ignored entirely; the pipeline stall logic, not this block, guarantees no such request is lost.
REQ-018 start with md_op none or reserved SHALL have no effect.
REQ-019 mult SHALL produce a signed 64-bit product and multu an unsigned one; {HI,LO} SHALL equal the product.
REQ-020 div SHALL produce a signed quotient truncated toward zero in LO and a remainder in HI carrying the dividend's sign; divu SHALL compute the same unsigned.
REQ-021 div of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-022 A divide with B==0 SHALL still occupy DIV_CYCLES busy cycles but SHALL leave HI/LO unchanged.
REQ-023 HI/LO SHALL change only at operation completion, on mthi/mtlo, or on reset; the pre-op values SHALL be visible throughout busy.
REQ-024 HI, LO and busy SHALL be driven from registers with no combinational path from the inputs.

Reset
REQ-025 reset=1 SHALL force state IDLE, counter 0, busy 0, HI 0 and LO 0 at the next edge, including mid-operation, and the in-flight result SHALL be discarded.
REQ-026 reset SHALL take priority over start in the same cycle.

Configuration
REQ-027 With macro MDU_MADD_EN defined, md_op 7-10 SHALL accumulate: madd {HI,LO}+=signed A*B, maddu adds the unsigned product, msub/msubu subtract it, all modulo 2^64 with MULT_CYCLES latency.
REQ-028 Without MDU_MADD_EN, md_op 7-10 SHALL be treated as none: no busy and no HI/LO change.

Verification
REQ-029 Bench SHALL drive reset, then mult A=0xFFFFFFFE B=3 and require busy high for cycles 1-5, then HI=0xFFFFFFFF and LO=0xFFFFFFFA with busy=0.
REQ-030 Bench SHALL drive divu A=7 B=2 and require 10 busy cycles, then LO=3 and HI=1; then div A=0xFFFFFFF9 (-7) B=2 and require LO=0xFFFFFFFD and HI=0xFFFFFFFF.
REQ-031 Bench SHALL drive mthi A=0x1234, then div A=5 B=0 and require 10 busy cycles with HI=0x1234 and LO unchanged throughout and after.
REQ-032 Bench SHALL drive start mult in cycle 2 of a running divu and require the mult to be ignored and the divu result correct with busy low after 10 cycles.
REQ-033 Bench SHALL assert reset at cycle 3 of mult A=B=0x10000 and require busy=0, HI=0 and LO=0 the next cycle with no later update.
REQ-034 Bench SHALL load HI=0, LO=1 and drive madd A=2 B=3 and require HI=0, LO=7 with MDU_MADD_EN defined, and HI=0, LO=1 with busy never high without it.
